// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   arb_state_t  - arbiter FSM state encoding (IDLE / LOCKED)
//   cnt_width()  - register width needed to hold counts 0 .. max_count-1
package uart_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   // Width of a counter that must represent 0 .. max_count-1.
   // Never narrower than one bit so a timeout of 2 still gets a real register.
   function automatic int cnt_width(input int max_count);
      if (max_count <= 2) begin
         return 1;
      end
      return $clog2(max_count);
   endfunction

endpackage : uart_pkg

// File: rtl/rr_arbiter.sv
// Round-robin winner select for the UART transmit arbiter.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the winner.
//
// Ports:
//   req        - request vector, one bit per requester
//   last_owner - index of the previous owner; search starts one above it
//   winner     - first requesting index found at or after last_owner+1 (mod NUM_REQ)
//   any_req    - at least one request bit is set (winner is only meaningful then)
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_owner,
   output logic [IDX_W-1:0]   winner,
   output logic               any_req
);

   // One extra bit so last_owner + offset never overflows before the wrap.
   localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

   logic [IDX_W:0] cand;
   logic           found;

   always_comb begin
      winner  = '0;
      any_req = |req;
      found   = 1'b0;
      cand    = '0;
      // Offsets 1..NUM_REQ visit every index exactly once, ending on last_owner
      // itself, so a lone requester is always re-granted.
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = {1'b0, last_owner} + (IDX_W+1)'(i);
         if (cand >= NUM_REQ_W) begin
            cand = cand - NUM_REQ_W;
         end
         if (!found && req[cand[IDX_W-1:0]]) begin
            winner = cand[IDX_W-1:0];
            found  = 1'b1;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte-stream requesters, packet-locked.
// Latency: one IDLE cycle to arbitrate; bytes then pass through combinationally.
// Backpressure: tx_rdy routes straight to the owner's req_rdy; no byte storage.
//
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   req_vld/_data/_last, req_rdy - per-requester byte stream (valid/ready)
//   tx_vld, tx_data, tx_rdy      - byte stream toward the shared transmitter
//   grant_id        - current or most recent owner index
//   busy            - a requester currently owns the transmitter
//   timeout_pulse   - one-cycle pulse when an owner is released for stalling
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int IDLE_TIMEOUT = 1024
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_REQ-1:0]                  req_vld,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
   input  logic [NUM_REQ-1:0]                  req_last,
   output logic [NUM_REQ-1:0]                  req_rdy,
   output logic                                tx_vld,
   output logic [DATA_WIDTH-1:0]               tx_data,
   input  logic                                tx_rdy,
   output logic [$clog2(NUM_REQ)-1:0]          grant_id,
   output logic                                busy,
   output logic                                timeout_pulse
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = cnt_width(IDLE_TIMEOUT);

   // Stall count at which the owner is forcibly released.
   localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(IDLE_TIMEOUT - 1);
   // Reset last_owner to the top index so requester 0 is searched first.
   localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

   // ------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------
   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $fatal(1, "uart_tx_arbiter: NUM_REQ=%0d outside 2..8", NUM_REQ);
   end
   if (IDLE_TIMEOUT < 2) begin : g_bad_timeout
      $fatal(1, "uart_tx_arbiter: IDLE_TIMEOUT=%0d must be >= 2", IDLE_TIMEOUT);
   end
   if (DATA_WIDTH < 1) begin : g_bad_width
      $fatal(1, "uart_tx_arbiter: DATA_WIDTH=%0d must be >= 1", DATA_WIDTH);
   end

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   arb_state_t       state;
   logic [IDX_W-1:0] last_owner;
   logic [CNT_W-1:0] stall_cnt;

   // Round-robin candidate, only consumed while IDLE.
   logic [IDX_W-1:0] rr_winner;
   logic             rr_any;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req        (req_vld),
      .last_owner (last_owner),
      .winner     (rr_winner),
      .any_req    (rr_any)
   );

   // Owner's stream, selected by the registered grant.
   logic                  own_vld;
   logic                  own_last;
   logic [DATA_WIDTH-1:0] own_data;

   assign own_vld  = req_vld[grant_id];
   assign own_last = req_last[grant_id];
   assign own_data = req_data[grant_id];

   // ------------------------------------------------------------------
   // FSM: IDLE arbitrates, LOCKED holds ownership until last byte or stall
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         last_owner    <= LAST_RESET;
         grant_id      <= '0;
         stall_cnt     <= '0;
         timeout_pulse <= 1'b0;
      end else begin
         timeout_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rr_any) begin
                  grant_id  <= rr_winner;
                  stall_cnt <= '0;
                  state     <= ST_LOCKED;
               end
            end

            ST_LOCKED: begin
               if (own_vld) begin
                  // A presented byte is not a stall, even if tx_rdy holds it.
                  stall_cnt <= '0;
                  if (tx_rdy && own_last) begin
                     state      <= ST_IDLE;
                     last_owner <= grant_id;
                  end
               end else if (stall_cnt == STALL_LAST) begin
                  state         <= ST_IDLE;
                  last_owner    <= grant_id;
                  stall_cnt     <= '0;
                  timeout_pulse <= 1'b1;
               end else begin
                  stall_cnt <= stall_cnt + CNT_W'(1);
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Datapath: combinational pass-through of the owner's stream
   // ------------------------------------------------------------------
   always_comb begin
      req_rdy = '0;
      tx_vld  = 1'b0;
      tx_data = '0;
      if (state == ST_LOCKED) begin
         tx_vld            = own_vld;
         req_rdy[grant_id] = tx_rdy;
         // Keep the transmitter bus quiet when nothing is offered.
         if (own_vld) begin
            tx_data = own_data;
         end
      end
   end

   assign busy = (state == ST_LOCKED);

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, IDLE_TIMEOUT=16).
// Latency: n/a.
// Backpressure: tx_rdy driven directly by the scenarios.
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int TO = 16;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NR-1:0]         req_vld;
   logic [NR-1:0][DW-1:0] req_data;
   logic [NR-1:0]         req_last;
   logic [NR-1:0]         req_rdy;
   logic                  tx_vld;
   logic [DW-1:0]         tx_data;
   logic                  tx_rdy;
   logic [1:0]            grant_id;
   logic                  busy;
   logic                  timeout_pulse;

   uart_tx_arbiter #(
      .NUM_REQ      (NR),
      .DATA_WIDTH   (DW),
      .IDLE_TIMEOUT (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_vld       (req_vld),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_rdy       (req_rdy),
      .tx_vld        (tx_vld),
      .tx_data       (tx_data),
      .tx_rdy        (tx_rdy),
      .grant_id      (grant_id),
      .busy          (busy),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Requester source model: per-requester byte list with a read pointer.
   logic [DW-1:0] src_dat [NR][8];
   logic          src_lst [NR][8];
   int            src_len [NR];
   int            src_ptr [NR];

   // Logs and snapshots taken at each negedge.
   logic [DW-1:0] got_q[$];
   int            grant_log[$];
   int            grant_cyc[$];
   int            pulse_cnt   = 0;
   int            pulse_cyc   = 0;
   int            last_hs_cyc = 0;
   int            cyc_n       = 0;
   logic          prev_busy   = 1'b0;
   logic          prev_pulse  = 1'b0;
   logic [NR-1:0] hs_pend;
   logic          s_busy, s_vld, s_pulse;
   logic [DW-1:0] s_data;
   logic [1:0]    s_grant;
   logic [NR-1:0] s_rdy;

   task automatic drive();
      for (int r = 0; r < NR; r++) begin
         if (src_ptr[r] < src_len[r]) begin
            req_vld[r]  = 1'b1;
            req_data[r] = src_dat[r][src_ptr[r]];
            req_last[r] = src_lst[r][src_ptr[r]];
         end else begin
            req_vld[r]  = 1'b0;
            req_data[r] = '0;
            req_last[r] = 1'b0;
         end
      end
   endtask

   // mode 0: last on final byte, 1: every byte is a packet, 2: no last at all
   task automatic load(input int r, input int n, input logic [7:0] base, input int mode);
      for (int k = 0; k < n; k++) begin
         src_dat[r][src_len[r]] = base + 8'(k);
         src_lst[r][src_len[r]] = (mode == 1) || (mode == 0 && k == n - 1);
         src_len[r]++;
      end
   endtask

   // One clock: sample/check at negedge, advance sources just after posedge.
   task automatic cyc();
      @(negedge clk);
      cyc_n++;
      s_busy  = busy;
      s_vld   = tx_vld;
      s_data  = tx_data;
      s_pulse = timeout_pulse;
      s_grant = grant_id;
      s_rdy   = req_rdy;
      chk("onehot0_req_rdy", 32'($onehot0(req_rdy)), 1);
      chk("tx_vld_in_idle", 32'(!busy && tx_vld), 0);
      chk("tx_data_zero_no_vld", 32'(!tx_vld && (tx_data != '0)), 0);
      chk("pulse_width", 32'(prev_pulse && timeout_pulse), 0);
      prev_pulse = timeout_pulse;
      if (timeout_pulse) begin
         pulse_cnt++;
         pulse_cyc = cyc_n;
      end
      if (busy && !prev_busy) begin
         grant_log.push_back(int'(grant_id));
         grant_cyc.push_back(cyc_n);
      end
      prev_busy = busy;
      if (tx_vld && tx_rdy) begin
         got_q.push_back(tx_data);
         last_hs_cyc = cyc_n;
      end
      hs_pend = req_vld & req_rdy;
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin
         if (hs_pend[r]) src_ptr[r]++;
      end
      drive();
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      tx_rdy = 1'b1;
      for (int r = 0; r < NR; r++) begin
         src_len[r] = 0;
         src_ptr[r] = 0;
      end
      drive();
      cyc();
      cyc();
      rst = 1'b0;
      got_q.delete();
      grant_log.delete();
      grant_cyc.delete();
      pulse_cnt = 0;
   endtask

   task automatic wait_bytes(input int n, input int budget, input string tag);
      int k = 0;
      while (got_q.size() < n && k < budget) begin
         cyc();
         k++;
      end
      chk(tag, 32'(got_q.size()), 32'(n));
   endtask

   function automatic logic [31:0] got_at(input int i);
      if (i < got_q.size()) return 32'(got_q[i]);
      return 32'hDEAD;
   endfunction

   function automatic logic [31:0] grant_at(input int i);
      if (i < grant_log.size()) return 32'(grant_log[i]);
      return 32'hDEAD;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] e1 [6];
      int         g2 [6];
      logic [7:0] e2 [6];
      int         k;

      // ---------------- reset values ----------------
      do_reset();
      chk("rst_req_rdy", 32'(s_rdy), 0);
      chk("rst_tx_vld", 32'(s_vld), 0);
      chk("rst_tx_data", 32'(s_data), 0);
      chk("rst_busy", 32'(s_busy), 0);
      chk("rst_pulse", 32'(s_pulse), 0);
      chk("rst_grant", 32'(s_grant), 0);

      // ---------------- two requesters, 3-byte packets ----------------
      load(0, 3, 8'hA0, 0);
      load(2, 3, 8'hC0, 0);
      drive();
      cyc();
      chk("t1_arb_cycle_busy", 32'(s_busy), 0);
      chk("t1_arb_cycle_vld", 32'(s_vld), 0);
      cyc();
      chk("t1_first_grant", 32'(s_grant), 0);
      chk("t1_first_vld", 32'(s_vld), 1);
      chk("t1_first_byte", 32'(s_data), 32'h0A0);
      wait_bytes(6, 20, "t1_byte_count");
      e1 = '{8'hA0, 8'hA1, 8'hA2, 8'hC0, 8'hC1, 8'hC2};
      for (int i = 0; i < 6; i++) chk($sformatf("t1_byte%0d", i), got_at(i), 32'(e1[i]));
      chk("t1_grant_n", 32'(grant_log.size()), 2);
      chk("t1_grant0", grant_at(0), 0);
      chk("t1_grant1", grant_at(1), 2);

      // ---------------- all four valid, 1-byte packets ----------------
      do_reset();
      for (int r = 0; r < NR; r++) load(r, 3, 8'(8'h10 * (r + 1)), 1);
      drive();
      k = 0;
      while (grant_log.size() < 6 && k < 40) begin
         cyc();
         k++;
      end
      chk("t2_grant_n", 32'(grant_log.size()), 6);
      g2 = '{0, 1, 2, 3, 0, 1};
      e2 = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h11, 8'h21};
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t2_grant%0d", i), grant_at(i), 32'(g2[i]));
         chk($sformatf("t2_byte%0d", i), got_at(i), 32'(e2[i]));
      end
      for (int i = 1; i < 6; i++) begin
         if (i < grant_cyc.size())
            chk($sformatf("t2_spacing%0d", i), 32'(grant_cyc[i] - grant_cyc[i-1]), 2);
      end

      // ---------------- stall timeout on req1 ----------------
      do_reset();
      load(1, 2, 8'hB0, 2);
      load(2, 1, 8'hC5, 0);
      drive();
      k = 0;
      while (pulse_cnt == 0 && k < 60) begin
         cyc();
         k++;
      end
      chk("t3_pulse_seen", 32'(pulse_cnt), 1);
      chk("t3_owner", grant_at(0), 1);
      chk("t3_pulse_delay", 32'(pulse_cyc - last_hs_cyc), 32'(TO + 1));
      chk("t3_busy_at_pulse", 32'(s_busy), 0);
      chk("t3_bytes_before", 32'(got_q.size()), 2);
      chk("t3_byte1", got_at(1), 32'h0B1);
      cyc();
      chk("t3_next_grant", 32'(s_grant), 2);
      chk("t3_next_vld", 32'(s_vld), 1);
      chk("t3_next_byte", 32'(s_data), 32'h0C5);
      cyc();
      cyc();
      chk("t3_single_pulse", 32'(pulse_cnt), 1);

      // ---------------- long back-pressure, no timeout ----------------
      do_reset();
      tx_rdy = 1'b0;
      load(0, 2, 8'hD0, 0);
      drive();
      cyc();
      for (int i = 0; i < 100; i++) begin
         cyc();
         chk("t4_hold", {23'd0, s_vld, s_data}, {23'd0, 1'b1, 8'hD0});
      end
      chk("t4_no_pulse", 32'(pulse_cnt), 0);
      chk("t4_still_busy", 32'(s_busy), 1);
      chk("t4_no_bytes", 32'(got_q.size()), 0);
      tx_rdy = 1'b1;
      wait_bytes(2, 10, "t4_byte_count");
      chk("t4_byte0", got_at(0), 32'h0D0);
      chk("t4_byte1", got_at(1), 32'h0D1);
      cyc();
      chk("t4_release", 32'(s_busy), 0);

      // ---------------- reset mid-packet ----------------
      do_reset();
      load(3, 4, 8'hE0, 0);
      drive();
      wait_bytes(2, 10, "t5_bytes_pre_rst");
      rst = 1'b1;
      cyc();
      cyc();
      chk("t5_rst_req_rdy", 32'(s_rdy), 0);
      chk("t5_rst_tx_vld", 32'(s_vld), 0);
      chk("t5_rst_tx_data", 32'(s_data), 0);
      chk("t5_rst_busy", 32'(s_busy), 0);
      chk("t5_rst_pulse", 32'(s_pulse), 0);
      chk("t5_rst_grant", 32'(s_grant), 0);
      rst = 1'b0;
      load(0, 1, 8'hF0, 0);
      drive();
      cyc();
      chk("t5_idle_after_rst", 32'(s_busy), 0);
      cyc();
      chk("t5_req0_priority", 32'(s_grant), 0);
      chk("t5_req0_byte", 32'(s_data), 32'h0F0);
      chk("t5_no_pulse", 32'(pulse_cnt), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule : tb_uart_tx_arbiter

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte-stream requesters; legal range 2..8.
REQ-002 Parameter DATA_WIDTH, default 8, byte width; SHALL match the shared transmitter.
REQ-003 Parameter IDLE_TIMEOUT, default 1024, cycles a locked requester may stall before forced release; legal range >= 2.
REQ-004 clk  input  1  clock; all logic SHALL be on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_vld  input  NUM_REQ  per-requester byte valid.
REQ-007 req_data  input  NUM_REQ x DATA_WIDTH  per-requester byte.
REQ-008 req_last  input  NUM_REQ  marks the final byte of a requester packet.
REQ-009 req_rdy  output  NUM_REQ  per-requester accept; at most one bit high.
REQ-010 tx_vld  output  1  byte valid toward the shared UART transmitter.
REQ-011 tx_data  output  DATA_WIDTH  byte toward the transmitter.
REQ-012 tx_rdy  input  1  transmitter accepts a byte when tx_vld && tx_rdy.
REQ-013 grant_id  output  clog2(NUM_REQ)  index of the current or most recent owner.
REQ-014 busy  output  1  high while a requester owns the transmitter.
REQ-015 timeout_pulse  output  1  one-cycle pulse on forced release.

Function
REQ-016 FSM states: IDLE, LOCKED; no other states.
REQ-017 IDLE: if any req_vld high, select a winner by round-robin starting at (last_owner+1) mod NUM_REQ, register it in grant_id, go to LOCKED next cycle; req_rdy and tx_vld SHALL be 0 in IDLE.
REQ-018 Arbitration latency: one cycle from req_vld seen in IDLE to LOCKED; first byte may transfer in the first LOCKED cycle.
REQ-019 LOCKED: tx_vld = req_vld[grant_id], tx_data = req_data[grant_id], req_rdy[grant_id] = tx_rdy, all other req_rdy bits 0 (combinational pass-through, no byte storage).
REQ-020 Ownership SHALL persist across bytes until a handshake with req_last[grant_id]=1; then next state IDLE and last_owner := grant_id.
REQ-021 tx_data SHALL be 0 when tx_vld is 0.
REQ-022 Stall counter: counts consecutive LOCKED cycles with req_vld[grant_id]=0; clears on any cycle with req_vld[grant_id]=1 and on entry to LOCKED.
REQ-023 When the stall counter reaches IDLE_TIMEOUT-1 with req_vld still 0: go to IDLE, assert timeout_pulse for exactly one cycle, last_owner := grant_id.
REQ-024 Requests from non-owners SHALL be ignored while LOCKED; no preemption.
REQ-025 Back-pressure (tx_rdy=0) SHALL NOT advance the stall counter while req_vld[grant_id]=1.
REQ-026 Wrap-around: after owner NUM_REQ-1, search SHALL restart at index 0.
REQ-027 Single requester active continuously SHALL be re-granted after one IDLE cycle between packets.
REQ-028 busy = (state == LOCKED).

Reset
REQ-029 On rst: state IDLE, last_owner = NUM_REQ-1 (requester 0 wins first), grant_id = 0, stall counter 0.
REQ-030 Reset values: req_rdy 0, tx_vld 0, tx_data 0, busy 0, timeout_pulse 0.
REQ-031 rst mid-packet SHALL abandon the packet without timeout_pulse; bytes already handed over are not recalled.

Structure
REQ-032 Shared package uart_pkg SHALL hold the FSM state enum and the helper function for counter width.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (combinational, inputs request vector and last_owner, outputs winner index and any_req).
REQ-034 Parameter checks (ranges in REQ-001/003) SHALL be elaboration-time assertions with $fatal.

Verification
REQ-035 Reset, then req_vld=4'b0101 each with 3-byte packets, tx_rdy=1 -> req0 granted first, then req2; tx_data sequence exactly matches packet order.
REQ-036 All 4 requesters continuously valid, 1-byte packets -> grant_id sequence 0,1,2,3,0,1 with one IDLE cycle between grants.
REQ-037 req1 owns, sends 2 bytes then drops req_vld for IDLE_TIMEOUT=16 cycles -> timeout_pulse one cycle, busy 0, next grant goes to req2 if valid.
REQ-038 tx_rdy held 0 for 100 cycles with req_vld[owner]=1, IDLE_TIMEOUT=16 -> no timeout, tx_vld/tx_data stable, transfer completes when tx_rdy=1.
REQ-039 rst asserted mid-packet of req3 -> next cycle all outputs at reset values; after release req0 has priority.
REQ-040 Assertions throughout: onehot0(req_rdy); tx_vld=0 in IDLE; timeout_pulse never two cycles wide.
